// File: rtl/serial_pkg.sv
// Framing constants shared by the serial transmitter and receiver, plus the
// receiver state encoding.
package serial_pkg;

    localparam logic [15:0] SOF_WORD   = 16'h5A5A;
    localparam logic [15:0] EOF_WORD   = 16'h0F0F;
    localparam int          SOF_REPEAT = 2;
    localparam int          EOF_REPEAT = 5;

    localparam logic [31:0] SOF_PATTERN = {SOF_WORD, SOF_WORD};
    localparam logic [31:0] EOF_PATTERN = {EOF_WORD, EOF_WORD};

    // Wide enough to count the 48 trailing EOF bits checked after EOF detection.
    localparam int                CNT_W      = 6;
    localparam logic [CNT_W-1:0]  CNT_ZERO   = 6'd0;
    localparam logic [CNT_W-1:0]  CNT_ONE    = 6'd1;
    localparam logic [CNT_W-1:0]  WORD_LAST  = 6'd31;
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'((EOF_REPEAT - 2) * 16 - 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_t;

    // Expected line bit at position pos (MSB-first) within one EOF unit.
    function automatic logic eof_bit(input logic [3:0] pos);
        logic [15:0] pat;
        pat = EOF_WORD;
        return pat[4'd15 - pos];
    endfunction

endpackage

// File: rtl/sipo_reg.sv
// 32-bit serial-in/parallel-out shift register; newest bit enters at bit 0.
module sipo_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [31:0] q
);

    // Shift one bit in every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 32'h0000_0000;
        end else begin
            q <= {q[30:0], din};
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Framed serial receiver: hunts for SOF, emits one FIFO write per data word
// and checks the EOF tail. Define SERIAL_RX_SYNC_EN to add a 2-flop input synchronizer.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DSIZE = 32
) (
    input  logic           wclk,
    input  logic           wrst_n,
    input  logic           s_in,
    input  logic           wfull,
    output logic [DSIZE:0] wdata,
    output logic           winc,
    output logic           frame_err,
    output logic           ovf
);

    logic             bit_s;
    logic [31:0]      sr_r;
    logic [31:0]      sr_next_s;
    logic [DSIZE-1:0] word_s;
    logic             sof_s;
    logic             is_eof_s;
    logic             wr_req_s;
    logic             wr_last_s;
    logic             sr_top_unused_s;

    rx_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DSIZE-1:0] pending_r;
    logic             pending_v_r;

`ifdef SERIAL_RX_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer for an asynchronous line.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], s_in};
        end
    end

    assign bit_s = sync_r[1];
`else
    assign bit_s = s_in;
`endif

    sipo_reg u_sipo (
        .clk   (wclk),
        .rst_n (wrst_n),
        .din   (bit_s),
        .q     (sr_r)
    );

    // The oldest bit drops out of the window once the new bit is appended.
    assign sr_top_unused_s = sr_r[31];

    // Decisions use the shift value including the bit sampled at this edge.
    always_comb begin
        sr_next_s = {sr_r[30:0], bit_s};
        word_s    = {sr_next_s[15:0], sr_next_s[31:16]};
        sof_s     = (state_r == ST_HUNT) && (sr_next_s == SOF_PATTERN);
        is_eof_s  = (word_s == EOF_PATTERN);
        if ((state_r == ST_DATA) && (cnt_r == WORD_LAST) && pending_v_r) begin
            wr_req_s  = 1'b1;
            wr_last_s = is_eof_s;
        end else begin
            wr_req_s  = 1'b0;
            wr_last_s = 1'b0;
        end
    end

    // Frame FSM with registered write, error and overflow outputs.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_r     <= ST_HUNT;
            cnt_r       <= CNT_ZERO;
            pending_r   <= {DSIZE{1'b0}};
            pending_v_r <= 1'b0;
            wdata       <= {(DSIZE + 1){1'b0}};
            winc        <= 1'b0;
            frame_err   <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            if (wr_req_s && !wfull) begin
                wdata <= {wr_last_s, pending_r};
                winc  <= 1'b1;
            end else begin
                winc  <= 1'b0;
            end

            if (wr_req_s && wfull) begin
                ovf <= 1'b1;
            end else if (sof_s) begin
                ovf <= 1'b0;
            end else begin
                ovf <= ovf;
            end

            case (state_r)
                ST_HUNT: begin
                    cnt_r <= CNT_ZERO;
                    if (sof_s) begin
                        state_r     <= ST_DATA;
                        pending_v_r <= 1'b0;
                    end else begin
                        state_r     <= ST_HUNT;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == WORD_LAST) begin
                        cnt_r <= CNT_ZERO;
                        if (is_eof_s) begin
                            // EOF with nothing pending means an empty frame.
                            frame_err   <= ~pending_v_r;
                            pending_v_r <= 1'b0;
                            state_r     <= ST_DRAIN;
                        end else begin
                            pending_r   <= word_s;
                            pending_v_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (bit_s != eof_bit(cnt_r[3:0])) begin
                        frame_err <= 1'b1;
                        state_r   <= ST_HUNT;
                        cnt_r     <= CNT_ZERO;
                    end else if (cnt_r == DRAIN_LAST) begin
                        state_r   <= ST_HUNT;
                        cnt_r     <= CNT_ZERO;
                    end else begin
                        cnt_r     <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_HUNT;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Directed self-checking bench for serial_rx; expected writes are queued as
// frames are driven and compared as winc strobes appear.
module tb_serial_rx;
    import serial_pkg::*;

`ifdef SERIAL_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        wclk   = 1'b0;
    logic        wrst_n = 1'b0;
    logic        s_in   = 1'b0;
    logic        wfull  = 1'b0;
    logic [32:0] wdata;
    logic        winc;
    logic        frame_err;
    logic        ovf;

    serial_rx #(.DSIZE(32)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .s_in      (s_in),
        .wfull     (wfull),
        .wdata     (wdata),
        .winc      (winc),
        .frame_err (frame_err),
        .ovf       (ovf)
    );

    always #5 wclk = ~wclk;

    int          tests       = 0;
    int          fails       = 0;
    int          cyc         = 0;
    int          n_wr        = 0;
    int          n_err       = 0;
    int          last_wr_cyc = -1;
    int          last_err_cyc = -1;
    logic        prev_winc   = 1'b0;
    logic [32:0] exp_q[$];

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge wclk) cyc <= cyc + 1;

    // Scoreboard monitor: pop and compare on each write strobe.
    always @(negedge wclk) begin
        if (winc) begin
            n_wr++;
            last_wr_cyc = cyc;
            chk("winc_back_to_back", {32'd0, prev_winc}, 33'd0);
            chk("sb_nonempty_at_write", 33'(exp_q.size() != 0), 33'd1);
            if (exp_q.size() != 0) chk("wdata", wdata, exp_q.pop_front());
        end
        if (frame_err) begin
            n_err++;
            last_err_cyc = cyc;
        end
        prev_winc <= winc;
    end

    task automatic send_bit(input logic b);
        s_in = b;
        @(posedge wclk);
        #1;
    endtask

    task automatic send16(input logic [15:0] u);
        for (int i = 15; i >= 0; i--) send_bit(u[i]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send16(w[15:0]);
        send16(w[31:16]);
    endtask

    task automatic send_sof();
        repeat (SOF_REPEAT) send16(SOF_WORD);
    endtask

    task automatic send_eof();
        repeat (EOF_REPEAT) send16(EOF_WORD);
    endtask

    task automatic idle(input int n);
        s_in = 1'b0;
        repeat (n) begin
            @(posedge wclk);
            #1;
        end
    endtask

    task automatic expect_wr(input logic last, input logic [31:0] w);
        exp_q.push_back({last, w});
    endtask

    initial begin
        int          w0;
        int          e0;
        int          mark;
        logic [15:0] u;

        idle(3);
        chk("rst_wdata", wdata, 33'd0);
        chk("rst_winc", {32'd0, winc}, 33'd0);
        chk("rst_frame_err", {32'd0, frame_err}, 33'd0);
        chk("rst_ovf", {32'd0, ovf}, 33'd0);
        chk("rst_state", 33'(dut.state_r), 33'(ST_HUNT));
        wrst_n = 1'b1;
        idle(2);

        // Single-word frame, with write latency measured from the 32nd EOF bit.
        w0 = n_wr; e0 = n_err;
        expect_wr(1'b1, 32'h1234_5678);
        send_sof();
        send_word(32'h1234_5678);
        send16(EOF_WORD);
        send16(EOF_WORD);
        mark = cyc;
        repeat (EOF_REPEAT - 2) send16(EOF_WORD);
        idle(LAT + 2);
        chk("t1_write_count", 33'(n_wr - w0), 33'd1);
        chk("t1_latency", 33'(last_wr_cyc), 33'(mark + LAT));
        chk("t1_no_err", 33'(n_err - e0), 33'd0);
        chk("t1_wdata_hold", wdata, 33'h1_1234_5678);

        // Two-word frame then a back-to-back second frame.
        w0 = n_wr; e0 = n_err;
        expect_wr(1'b0, 32'hDEAD_BEEF);
        expect_wr(1'b1, 32'h0000_0001);
        expect_wr(1'b1, 32'hCAFE_F00D);
        send_sof();
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0001);
        send_eof();
        send_sof();
        send_word(32'hCAFE_F00D);
        send_eof();
        idle(LAT + 2);
        chk("t2_write_count", 33'(n_wr - w0), 33'd3);
        chk("t2_no_err", 33'(n_err - e0), 33'd0);

        // FIFO full when the first of three words is written.
        w0 = n_wr;
        expect_wr(1'b0, 32'h3333_4444);
        expect_wr(1'b1, 32'h5555_6666);
        send_sof();
        send_word(32'h1111_2222);
        wfull = 1'b1;
        send_word(32'h3333_4444);
        u = 16'h6666;
        for (int i = 0; i < 16; i++) begin
            if (i == LAT) wfull = 1'b0;
            send_bit(u[15 - i]);
        end
        send16(16'h5555);
        chk("t3_ovf_set", {32'd0, ovf}, 33'd1);
        send_eof();
        idle(LAT + 2);
        chk("t3_ovf_sticky", {32'd0, ovf}, 33'd1);
        chk("t3_write_count", 33'(n_wr - w0), 33'd2);

        // Empty frame: ovf clears at SOF, one frame_err, no write.
        w0 = n_wr; e0 = n_err;
        send_sof();
        send16(EOF_WORD);
        chk("t4_ovf_cleared", {32'd0, ovf}, 33'd0);
        send16(EOF_WORD);
        mark = cyc;
        repeat (EOF_REPEAT - 2) send16(EOF_WORD);
        idle(LAT + 2);
        chk("t4_err_count", 33'(n_err - e0), 33'd1);
        chk("t4_err_latency", 33'(last_err_cyc), 33'(mark + LAT));
        chk("t4_no_write", 33'(n_wr - w0), 33'd0);

        // Corrupted third EOF unit, then a clean frame.
        w0 = n_wr; e0 = n_err;
        expect_wr(1'b1, 32'h89AB_CDEF);
        send_sof();
        send_word(32'h89AB_CDEF);
        send16(EOF_WORD);
        send16(EOF_WORD);
        u = 16'h0F1F;
        for (int i = 0; i < 16; i++) begin
            send_bit(u[15 - i]);
            if (i == 11) mark = cyc;
        end
        chk("t5_err_count", 33'(n_err - e0), 33'd1);
        chk("t5_err_latency", 33'(last_err_cyc), 33'(mark + LAT));
        chk("t5_state_hunt", 33'(dut.state_r), 33'(ST_HUNT));
        expect_wr(1'b1, 32'hA5A5_C3C3);
        send_sof();
        send_word(32'hA5A5_C3C3);
        send_eof();
        idle(LAT + 2);
        chk("t5_write_count", 33'(n_wr - w0), 33'd2);
        chk("t5_err_after", 33'(n_err - e0), 33'd1);

        // Reset in the middle of the second data word.
        w0 = n_wr;
        send_sof();
        send_word(32'hAAAA_5555);
        send16(16'h1234);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("t6_rst_wdata", wdata, 33'd0);
        chk("t6_rst_winc", {32'd0, winc}, 33'd0);
        chk("t6_rst_frame_err", {32'd0, frame_err}, 33'd0);
        chk("t6_rst_ovf", {32'd0, ovf}, 33'd0);
        idle(2);
        wrst_n = 1'b1;
        idle(2);
        chk("t6_no_write_after_rst", 33'(n_wr - w0), 33'd0);
        expect_wr(1'b1, 32'h600D_CAFE);
        send_sof();
        send_word(32'h600D_CAFE);
        send16(EOF_WORD);
        send16(EOF_WORD);
        mark = cyc;
        repeat (EOF_REPEAT - 2) send16(EOF_WORD);
        idle(LAT + 4);
        chk("t6_write_count", 33'(n_wr - w0), 33'd1);
        chk("t6_latency", 33'(last_wr_cyc), 33'(mark + LAT));
        chk("t6_wdata_hold", wdata, 33'h1_600D_CAFE);

        chk("sb_empty", 33'(exp_q.size()), 33'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
